// File: rtl/ff_pipe_hab_pkg.sv
// ff_pipe_hab_pkg: shared fixed-point constants for the integrator pipeline blocks.
`default_nettype none

package ff_pipe_hab_pkg;

  // Q-format zero; every integrator block clears and primes from this value.
  localparam logic [63:0] FX_RESET_VALUE = 64'h0;

  // Low bit of channel c in a bus packing lanes of width w.
  function automatic int unsigned lane_offset(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ff_pipe_hab_pipe_stage.sv
// ff_pipe_hab_pipe_stage: one multi-channel register plus valid bit.
// Control priority is clr > load > en > hold.
`default_nettype none

module ff_pipe_hab_pipe_stage
  import ff_pipe_hab_pkg::*;
#(
  parameter int unsigned       Width      = 32,
  parameter int unsigned       Channels   = 3,
  parameter logic [Width-1:0]  ResetValue = FX_RESET_VALUE[Width-1:0]
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        load_i,
  input  logic                        en_i,
  input  logic [Channels*Width-1:0]   init_i,
  input  logic [Channels*Width-1:0]   d_i,
  input  logic                        valid_i,
  output logic [Channels*Width-1:0]   q_o,
  output logic                        valid_o
);

  logic [Channels*Width-1:0] reset_word;

  for (genvar c = 0; c < Channels; c++) begin : g_lane
    assign reset_word[lane_offset(c, Width) +: Width] = ResetValue;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o     <= reset_word;
      valid_o <= 1'b0;
    end else if (clr_i) begin
      q_o     <= reset_word;
      valid_o <= 1'b0;
    end else if (load_i) begin
      q_o     <= init_i;
      valid_o <= 1'b1;
    end else if (en_i) begin
      q_o     <= d_i;
      valid_o <= valid_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ff_pipe_hab.sv
// ff_pipe_hab: Depth-stage multi-channel pipeline register with valid tracking,
// primed flag and a wrapping count of valid samples emitted.
`default_nettype none

module ff_pipe_hab
  import ff_pipe_hab_pkg::*;
#(
  parameter int unsigned       Width      = 32,
  parameter int unsigned       Channels   = 3,
  parameter int unsigned       Depth      = 2,
  parameter logic [Width-1:0]  ResetValue = FX_RESET_VALUE[Width-1:0],
  parameter int unsigned       CntWidth   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        clr_i,
  input  logic                        load_i,
  input  logic [Channels*Width-1:0]   init_i,
  input  logic [Channels*Width-1:0]   d_i,
  input  logic                        valid_i,
  output logic [Channels*Width-1:0]   q_o,
  output logic                        valid_o,
  output logic                        primed_o,
  output logic [CntWidth-1:0]         step_cnt_o
);

  // Index k is the input of stage k; index Depth is the last stage output.
  logic [Channels*Width-1:0] chain_data [0:Depth];
  logic [Depth:0]            chain_valid;

  assign chain_data[0]  = d_i;
  assign chain_valid[0] = valid_i;

  for (genvar k = 0; k < Depth; k++) begin : g_stage
    ff_pipe_hab_pipe_stage #(
      .Width      (Width),
      .Channels   (Channels),
      .ResetValue (ResetValue)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clr_i),
      .load_i  (load_i),
      .en_i    (en_i),
      .init_i  (init_i),
      .d_i     (chain_data[k]),
      .valid_i (chain_valid[k]),
      .q_o     (chain_data[k+1]),
      .valid_o (chain_valid[k+1])
    );
  end

  assign q_o     = chain_data[Depth];
  assign valid_o = chain_valid[Depth];

  // On a shift, the valids about to land in stages 0..Depth-1 are chain_valid[Depth-1:0].
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      primed_o   <= 1'b0;
      step_cnt_o <= '0;
    end else if (clr_i) begin
      primed_o   <= 1'b0;
      step_cnt_o <= '0;
    end else if (load_i) begin
      primed_o   <= 1'b1;
    end else if (en_i) begin
      primed_o <= &chain_valid[Depth-1:0];
      if (chain_valid[Depth-1])
        step_cnt_o <= step_cnt_o + CntWidth'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ff_pipe_hab.sv
// tb_ff_pipe_hab: directed-vector bench for ff_pipe_hab (Width=8, Channels=2, Depth=3, CntWidth=4).
`default_nettype none

module tb_ff_pipe_hab;

  localparam int unsigned Width    = 8;
  localparam int unsigned Channels = 2;
  localparam int unsigned Depth    = 3;
  localparam int unsigned CntWidth = 4;

  logic                      clk_i;
  logic                      rst_i;
  logic                      en_i;
  logic                      clr_i;
  logic                      load_i;
  logic [Channels*Width-1:0] init_i;
  logic [Channels*Width-1:0] d_i;
  logic                      valid_i;
  logic [Channels*Width-1:0] q_o;
  logic                      valid_o;
  logic                      primed_o;
  logic [CntWidth-1:0]       step_cnt_o;

  int n_cmp;
  int n_bad;

  ff_pipe_hab #(
    .Width      (Width),
    .Channels   (Channels),
    .Depth      (Depth),
    .ResetValue (8'h00),
    .CntWidth   (CntWidth)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .init_i     (init_i),
    .d_i        (d_i),
    .valid_i    (valid_i),
    .q_o        (q_o),
    .valid_o    (valid_o),
    .primed_o   (primed_o),
    .step_cnt_o (step_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] q, input logic v,
                           input logic p, input logic [3:0] cnt);
    check({tag, ".q"},      32'(q_o),        32'(q));
    check({tag, ".valid"},  32'(valid_o),    32'(v));
    check({tag, ".primed"}, 32'(primed_o),   32'(p));
    check({tag, ".cnt"},    32'(step_cnt_o), 32'(cnt));
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_i   = 1'b1;
    en_i    = 1'b0;
    clr_i   = 1'b0;
    load_i  = 1'b0;
    init_i  = '0;
    d_i     = '0;
    valid_i = 1'b0;
    #3;
    check_out("por", 16'h0000, 1'b0, 1'b0, 4'd0);
    step();
    rst_i = 1'b0;

    // Basic streaming, then async reset with data in flight
    en_i = 1'b1; valid_i = 1'b1;
    d_i = 16'h1001; step();
    d_i = 16'h2002; step();
    check_out("lat_e2", 16'h0000, 1'b0, 1'b0, 4'd0);
    d_i = 16'h3003; step();
    check_out("lat_e3", 16'h1001, 1'b1, 1'b1, 4'd1);
    d_i = 16'h4004; step();
    check_out("lat_e4", 16'h2002, 1'b1, 1'b1, 4'd2);
    #2 rst_i = 1'b1;
    #1 check_out("async_rst", 16'h0000, 1'b0, 1'b0, 4'd0);
    #1 rst_i = 1'b0;

    // Enable gap stretches latency without loss or repeat
    en_i = 1'b1; valid_i = 1'b1;
    d_i = 16'h1001; step();
    d_i = 16'h2002; step();
    en_i = 1'b0; d_i = 16'hFFFF;
    step(); check_out("gap_e3", 16'h0000, 1'b0, 1'b0, 4'd0);
    step(); check_out("gap_e4", 16'h0000, 1'b0, 1'b0, 4'd0);
    en_i = 1'b1; d_i = 16'h3003; step();
    check_out("gap_e5", 16'h1001, 1'b1, 1'b1, 4'd1);
    d_i = 16'h4004; step();
    check_out("gap_e6", 16'h2002, 1'b1, 1'b1, 4'd2);
    en_i = 1'b0; d_i = 16'hEEEE; step();
    check_out("hold_e7", 16'h2002, 1'b1, 1'b1, 4'd2);
    en_i = 1'b1; valid_i = 1'b0; d_i = 16'h0000; step();
    check_out("gap_e8", 16'h3003, 1'b1, 1'b0, 4'd3);
    step();
    check_out("gap_e9", 16'h4004, 1'b1, 1'b0, 4'd4);

    // Load beats enable; every stage gets init_i
    load_i = 1'b1; en_i = 1'b1; valid_i = 1'b1;
    init_i = 16'h55AA; d_i = 16'hFFFF; step();
    check_out("load", 16'h55AA, 1'b1, 1'b1, 4'd4);
    load_i = 1'b0; valid_i = 1'b0; d_i = 16'h7777; step();
    check_out("load_s1", 16'h55AA, 1'b1, 1'b0, 4'd5);
    step();
    check_out("load_s2", 16'h55AA, 1'b1, 1'b0, 4'd6);
    step();
    check_out("load_s3", 16'h7777, 1'b0, 1'b0, 4'd6);

    // Clear beats load and enable
    clr_i = 1'b1; load_i = 1'b1; en_i = 1'b1; valid_i = 1'b1; step();
    check_out("clr", 16'h0000, 1'b0, 1'b0, 4'd0);
    clr_i = 1'b0; load_i = 1'b0;

    // Counter wrap at CntWidth=4
    en_i = 1'b1; valid_i = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      d_i = {8'(i), 8'(i)};
      step();
    end
    check_out("wrap_15", 16'h0F0F, 1'b1, 1'b1, 4'd15);
    d_i = 16'h1212; step();
    check("wrap_0.cnt", 32'(step_cnt_o), 32'd0);
    d_i = 16'h1313; step();
    check("wrap_1.cnt", 32'(step_cnt_o), 32'd1);
    valid_i = 1'b0; d_i = 16'hABCD; step();
    check("wrap_2.cnt", 32'(step_cnt_o), 32'd2);
    valid_i = 1'b1; d_i = 16'h1515; step();
    check_out("inv_pre", 16'h1313, 1'b1, 1'b0, 4'd3);
    step();
    check_out("inv_out", 16'hABCD, 1'b0, 1'b0, 4'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
